fsm_sequence_generator: RTL and testbench

Serial bit-pattern transmitter; the generating counterpart to the team's sequence detectors. It accepts a PAT_W-bit pattern on a start handshake and shifts it out MSB-first, one bit per clock, on the serial line `x`. An idle gap follows each frame. It drives detector inputs in FSM test fixtures and acts as a simple framed serial source in datapaths.

---
 rtl/fsm_seq_pkg.sv | 19 +
 rtl/seq_piso_shift.sv | 38 +++
 rtl/fsm_sequence_generator.sv | 140 ++++++++++++++
 tb/tb_fsm_sequence_generator.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_seq_pkg.sv
// Shared types and sizing helpers for the serial sequence generator.
// State encoding, default geometry and counter-width function.
package fsm_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_e;

   localparam int PAT_W_DEF      = 3;
   localparam int GAP_CYCLES_DEF = 1;

   // Width needed to hold values 0..n-1, never less than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seq_piso_shift.sv
// Parallel-load, MSB-first, left-shift register with zero fill.
// Load has priority over shift; msb is the bit currently presented.
module seq_piso_shift #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         aresetn,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] d,
   output logic         msb
);

   logic [W-1:0] sr_q;
   logic [W-1:0] sr_d;

   // Next register contents: parallel load, else shift left.
   always_comb begin
      sr_d = sr_q;
      if (load) begin
         sr_d = d;
      end else if (shift) begin
         sr_d = {sr_q[W-2:0], 1'b0};
      end
   end

   // Register update with synchronous active-low clear.
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign msb = sr_q[W-1];

endmodule

// File: rtl/fsm_sequence_generator.sv
// Framed MSB-first serial pattern transmitter with idle gap.
// Optional back-to-back repeat mode under SEQGEN_REPEAT_EN.
module fsm_sequence_generator
   import fsm_seq_pkg::*;
#(
   parameter int PAT_W      = PAT_W_DEF,
   parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
   input  logic             clk,
   input  logic             aresetn,
`ifdef SEQGEN_REPEAT_EN
   input  logic             repeat_en,
`endif
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   output logic             ready,
   output logic             x,
   output logic             x_valid,
   output logic             done
);

   localparam int CW = cnt_w(PAT_W);
   localparam int GW = cnt_w(GAP_CYCLES + 1);

   localparam logic [CW-1:0] CNT_LOAD = CW'(PAT_W - 1);
   localparam logic [GW-1:0] GAP_LOAD =
      (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

   state_e          state_q;
   state_e          state_d;
   logic [CW-1:0]   cnt_q;
   logic [CW-1:0]   cnt_d;
   logic [GW-1:0]   gap_q;
   logic [GW-1:0]   gap_d;
   logic            sr_load;
   logic            sr_shift;
   logic [PAT_W-1:0] sr_val;
   logic            sr_msb;

`ifdef SEQGEN_REPEAT_EN
   logic [PAT_W-1:0] hold_q;
   logic [PAT_W-1:0] hold_d;
`endif

   // Next-state, counter and shift-control decode.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      gap_d    = gap_q;
      sr_load  = 1'b0;
      sr_shift = 1'b0;
      sr_val   = pattern;
`ifdef SEQGEN_REPEAT_EN
      hold_d   = hold_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               sr_load = 1'b1;
               cnt_d   = CNT_LOAD;
               state_d = SHIFT;
`ifdef SEQGEN_REPEAT_EN
               hold_d  = pattern;
`endif
            end
         end
         SHIFT: begin
            sr_shift = 1'b1;
            if (cnt_q == '0) begin
               state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
               gap_d   = GAP_LOAD;
`ifdef SEQGEN_REPEAT_EN
               if (repeat_en) begin
                  sr_load = 1'b1;
                  sr_val  = hold_q;
                  cnt_d   = CNT_LOAD;
                  state_d = SHIFT;
               end
`endif
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         GAP: begin
            if (gap_q == '0) begin
               state_d = IDLE;
            end else begin
               gap_d = gap_q - GW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and counter registers, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
      end
   end

`ifdef SEQGEN_REPEAT_EN
   // Held copy of the accepted pattern for repeat reloads.
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         hold_q <= '0;
      end else begin
         hold_q <= hold_d;
      end
   end
`endif

   seq_piso_shift #(
      .W (PAT_W)
   ) u_piso (
      .clk     (clk),
      .aresetn (aresetn),
      .load    (sr_load),
      .shift   (sr_shift),
      .d       (sr_val),
      .msb     (sr_msb)
   );

   // Moore outputs decoded only from registered state and datapath.
   always_comb begin
      ready   = (state_q == IDLE);
      x_valid = (state_q == SHIFT);
      x       = (state_q == SHIFT) & sr_msb;
      done    = (state_q == SHIFT) & (cnt_q == '0);
   end

endmodule

// File: tb/tb_fsm_sequence_generator.sv
// Directed bench for fsm_sequence_generator (gap 1 and gap 0 copies).
// Observed bundles are {ready, x, x_valid, done}.
module tb_fsm_sequence_generator;

   logic       clk;
   logic       aresetn;
   logic       start;
   logic [2:0] pattern;
   logic       start1;
   logic [2:0] pattern1;
   logic       rep;
   logic       rep1;
   logic       ready0, x0, xv0, done0;
   logic       ready1, x1, xv1, done1;
   logic [3:0] o0;
   logic [3:0] o1;

   int checks   = 0;
   int failures = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   fsm_sequence_generator #(
      .PAT_W      (3),
      .GAP_CYCLES (1)
   ) dut0 (
      .clk       (clk),
      .aresetn   (aresetn),
`ifdef SEQGEN_REPEAT_EN
      .repeat_en (rep),
`endif
      .start     (start),
      .pattern   (pattern),
      .ready     (ready0),
      .x         (x0),
      .x_valid   (xv0),
      .done      (done0)
   );

   fsm_sequence_generator #(
      .PAT_W      (3),
      .GAP_CYCLES (0)
   ) dut1 (
      .clk       (clk),
      .aresetn   (aresetn),
`ifdef SEQGEN_REPEAT_EN
      .repeat_en (rep1),
`endif
      .start     (start1),
      .pattern   (pattern1),
      .ready     (ready1),
      .x         (x1),
      .x_valid   (xv1),
      .done      (done1)
   );

   assign o0 = {ready0, x0, xv0, done0};
   assign o1 = {ready1, x1, xv1, done1};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs,
                      input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
      end
   endtask

   initial begin
      aresetn  = 1'b0;
      start    = 1'b0;
      pattern  = 3'b000;
      start1   = 1'b0;
      pattern1 = 3'b000;
      rep      = 1'b0;
      rep1     = 1'b0;
      step();
      step();
      chk("rst0", o0, 4'b1000);
      chk("rst1", o1, 4'b1000);
      aresetn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("idle0", o0, 4'b1000);
         chk("idle1", o1, 4'b1000);
      end

      // single frame 101, start during frame must be ignored
      pattern = 3'b101;
      start   = 1'b1;
      step();
      start   = 1'b0;
      pattern = 3'b111;
      chk("f1_b0", o0, 4'b0110);
      start = 1'b1;
      step();
      chk("f1_b1", o0, 4'b0010);
      start = 1'b0;
      step();
      chk("f1_b2", o0, 4'b0111);
      step();
      chk("f1_gap", o0, 4'b0000);
      step();
      chk("f1_rdy", o0, 4'b1000);
      step();
      chk("f1_noq", o0, 4'b1000);

      // start held high, pattern changes mid-frame
      pattern = 3'b110;
      start   = 1'b1;
      step();
      chk("c1_b0", o0, 4'b0110);
      pattern = 3'b011;
      step();
      chk("c1_b1", o0, 4'b0110);
      step();
      chk("c1_b2", o0, 4'b0011);
      step();
      chk("c1_gap", o0, 4'b0000);
      step();
      chk("c1_rdy", o0, 4'b1000);
      step();
      chk("c2_b0", o0, 4'b0010);
      start = 1'b0;
      step();
      chk("c2_b1", o0, 4'b0110);
      step();
      chk("c2_b2", o0, 4'b0111);
      step();
      chk("c2_gap", o0, 4'b0000);
      step();
      chk("c2_rdy", o0, 4'b1000);

      // reset during second bit aborts frame
      pattern = 3'b101;
      start   = 1'b1;
      step();
      start = 1'b0;
      chk("mr_b0", o0, 4'b0110);
      step();
      chk("mr_b1", o0, 4'b0010);
      aresetn = 1'b0;
      step();
      chk("mr_abort", o0, 4'b1000);
      aresetn = 1'b1;
      step();
      chk("mr_idle", o0, 4'b1000);
      step();
      chk("mr_nodone", o0, 4'b1000);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("mr2_b0", o0, 4'b0110);
      step();
      chk("mr2_b1", o0, 4'b0010);
      step();
      chk("mr2_b2", o0, 4'b0111);
      step();
      chk("mr2_gap", o0, 4'b0000);
      step();
      chk("mr2_rdy", o0, 4'b1000);

      // zero-gap copy, start held for two frames
      pattern1 = 3'b011;
      start1   = 1'b1;
      step();
      chk("g0_b0", o1, 4'b0010);
      step();
      chk("g0_b1", o1, 4'b0110);
      step();
      chk("g0_b2", o1, 4'b0111);
      step();
      chk("g0_rdy", o1, 4'b1000);
      step();
      chk("g0_f2b0", o1, 4'b0010);
      start1 = 1'b0;
      step();
      chk("g0_f2b1", o1, 4'b0110);
      step();
      chk("g0_f2b2", o1, 4'b0111);
      step();
      chk("g0_end", o1, 4'b1000);

`ifdef SEQGEN_REPEAT_EN
      begin
         logic [2:0] hist;
         int         det;
         logic [3:0] exp_o;
         hist    = 3'b000;
         det     = 0;
         pattern = 3'b101;
         rep     = 1'b1;
         start   = 1'b1;
         step();
         start = 1'b0;
         for (int i = 0; i < 9; i++) begin
            exp_o = {1'b0, (i % 3) != 1, 1'b1, (i % 3) == 2};
            chk("rep_bit", o0, exp_o);
            if (xv0) begin
               hist = {hist[1:0], x0};
               if (hist == 3'b101) det++;
            end
            if (i == 8) rep = 1'b0;
            step();
         end
         chk("rep_gap", o0, 4'b0000);
         step();
         chk("rep_rdy", o0, 4'b1000);
         chk("rep_det", 4'(det), 4'd3);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
